fetch_sequencer: RTL

// - Run-control FSM that drives the fetch unit's start/start_addr/taken/target/halt inputs.
// - Launches a program at a given address, forwards branch redirects from execute,

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_sequencer_sat_counter.sv | 25 ++
 rtl/fetch_sequencer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch run-control block.
package fetch_pkg;

    localparam int PC_W_DEFAULT = 8;
    localparam int SQ_W         = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        RUN    = 3'd2,
        FLUSH  = 3'd3,
        HALTED = 3'd4
    } seq_state_t;

endpackage

// File: rtl/fetch_sequencer_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         f_clk,
    input  logic         f_rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count
);

    // Count register: clear wins over enable, saturate at the top.
    always_ff @(posedge f_clk or posedge f_rst) begin
        if (f_rst) begin
            count <= {W{1'b0}};
        end else if (clr) begin
            count <= {W{1'b0}};
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Run-control FSM driving the fetch unit: launch, branch redirect/squash,
// stall hold, HALT and watchdog stop, plus cycle/instruction counters.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int PC_W       = PC_W_DEFAULT,
    parameter int CNT_W      = 32,
    parameter int BR_PENALTY = 1,
    parameter int MAX_CYCLES = 0
) (
    input  logic             f_clk,
    input  logic             f_rst,
    input  logic             go_i,
    input  logic [PC_W-1:0]  go_addr_i,
    input  logic             stall_i,
    input  logic             branch_i,
    input  logic             cond_i,
    input  logic [PC_W-1:0]  br_target_i,
    input  logic             halt_instr_i,
    output logic             start_o,
    output logic [PC_W-1:0]  start_addr_o,
    output logic             taken_o,
    output logic [PC_W-1:0]  target_o,
    output logic             halt_o,
    output logic             squash_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] cycle_count_o,
    output logic [CNT_W-1:0] instr_count_o
);

    localparam logic             WD_EN   = (MAX_CYCLES > 0);
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((MAX_CYCLES > 0) ? (MAX_CYCLES - 1) : 0);
    localparam logic [SQ_W-1:0]  SQ_INIT = SQ_W'(BR_PENALTY);

    seq_state_t       state_r;
    logic [PC_W-1:0]  addr_r;
    logic [SQ_W-1:0]  squash_cnt_r;
    logic             timeout_r;

    logic [CNT_W-1:0] cycle_cnt_s;
    logic [CNT_W-1:0] instr_cnt_s;
    logic             active_s;
    logic             launch_s;
    logic             wd_hit_s;
    logic             take_s;
    logic             halt_hit_s;
    logic             issue_s;

    assign active_s      = (state_r == RUN) || (state_r == FLUSH);
    assign launch_s      = (state_r == LAUNCH);
    assign wd_hit_s      = WD_EN && active_s && (cycle_cnt_s == WD_LAST);
    assign timeout_o     = timeout_r;
    assign cycle_count_o = cycle_cnt_s;
    assign instr_count_o = instr_cnt_s;

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .f_clk (f_clk),
        .f_rst (f_rst),
        .en    (active_s),
        .clr   (launch_s),
        .count (cycle_cnt_s)
    );

    sat_counter #(.W(CNT_W)) u_instr_cnt (
        .f_clk (f_clk),
        .f_rst (f_rst),
        .en    (issue_s),
        .clr   (launch_s),
        .count (instr_cnt_s)
    );

    // Fetch-side outputs and per-cycle decisions, decoded from state and live inputs.
    always_comb begin
        start_o      = 1'b0;
        start_addr_o = {PC_W{1'b0}};
        taken_o      = 1'b0;
        target_o     = {PC_W{1'b0}};
        halt_o       = 1'b1;
        squash_o     = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        take_s       = 1'b0;
        halt_hit_s   = 1'b0;
        issue_s      = 1'b0;
        case (state_r)
            IDLE: begin
                halt_o = 1'b1;
            end
            LAUNCH: begin
                start_o      = 1'b1;
                start_addr_o = addr_r;
                halt_o       = 1'b0;
                busy_o       = 1'b1;
            end
            RUN: begin
                busy_o = 1'b1;
                // A same-cycle HALT behind a taken branch is wrong-path, so the branch wins;
                // the watchdog in turn cancels the redirect.
                if (branch_i && cond_i) begin
                    if (wd_hit_s) begin
                        halt_o = 1'b1;
                    end else begin
                        take_s   = 1'b1;
                        taken_o  = 1'b1;
                        target_o = br_target_i;
                        halt_o   = 1'b0;
                    end
                end else if (halt_instr_i) begin
                    halt_hit_s = 1'b1;
                    halt_o     = 1'b1;
                end else if (stall_i) begin
                    halt_o = 1'b1;
                end else begin
                    halt_o  = 1'b0;
                    issue_s = 1'b1;
                end
            end
            FLUSH: begin
                busy_o   = 1'b1;
                squash_o = 1'b1;
                halt_o   = stall_i;
            end
            HALTED: begin
                halt_o = 1'b1;
                done_o = 1'b1;
            end
            default: begin
                halt_o = 1'b1;
            end
        endcase
    end

    // FSM state, launch address, squash countdown and sticky watchdog flag.
    always_ff @(posedge f_clk or posedge f_rst) begin
        if (f_rst) begin
            state_r      <= IDLE;
            addr_r       <= {PC_W{1'b0}};
            squash_cnt_r <= {SQ_W{1'b0}};
            timeout_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE, HALTED: begin
                    if (go_i) begin
                        addr_r  <= go_addr_i;
                        state_r <= LAUNCH;
                    end else begin
                        state_r <= state_r;
                    end
                end
                LAUNCH: begin
                    timeout_r <= 1'b0;
                    state_r   <= RUN;
                end
                RUN: begin
                    if (wd_hit_s) begin
                        timeout_r <= 1'b1;
                        state_r   <= HALTED;
                    end else if (take_s) begin
                        squash_cnt_r <= SQ_INIT;
                        state_r      <= FLUSH;
                    end else if (halt_hit_s) begin
                        state_r <= HALTED;
                    end else begin
                        state_r <= RUN;
                    end
                end
                FLUSH: begin
                    if (wd_hit_s) begin
                        timeout_r <= 1'b1;
                        state_r   <= HALTED;
                    end else if (stall_i) begin
                        state_r <= FLUSH;
                    end else if (squash_cnt_r <= {{(SQ_W-1){1'b0}}, 1'b1}) begin
                        squash_cnt_r <= {SQ_W{1'b0}};
                        state_r      <= RUN;
                    end else begin
                        squash_cnt_r <= squash_cnt_r - {{(SQ_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
